// File: rtl/wb_pkg.sv
// Shared constants and types for the Dioptase writeback stage.
package wb_pkg;

   localparam logic [7:0] EXC_BUS        = 8'h02;
   localparam logic [7:0] EXC_MISALIGNED = 8'h03;
   localparam logic [4:0] PRIV_RFE       = 5'd2;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      IDLE,
      WAIT
   } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Little-endian, zero-extending extraction of a load result from a bus word.
module load_align
   import wb_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr,
   input  logic [1:0]  i_size,
   output logic [31:0] o_data
);

   always_comb begin
      o_data = i_rdata;
      case (i_size)
         SZ_BYTE: o_data = {24'h000000, i_rdata[{i_addr, 3'b000} +: 8]};
         SZ_HALF: o_data = {16'h0000, i_rdata[{i_addr[1], 4'b0000} +: 16]};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/writeback.sv
// Dioptase writeback stage: load merge, register commit, exceptions and load-timeout FSM.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module writeback
   import wb_pkg::*;
#(
   parameter int unsigned LOAD_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic        halt,
   input  logic        bubble_in,
   input  logic [4:0]  opcode_in,
   input  logic [4:0]  tgt_in_1,
   input  logic [4:0]  tgt_in_2,
   input  logic [31:0] result_in_1,
   input  logic [31:0] result_in_2,
   input  logic [31:0] addr_in,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        is_misaligned,
   input  logic        tgts_cr,
   input  logic [1:0]  mem_size_in,
   input  logic [31:0] mem_pc_in,
   input  logic [7:0]  exc_in,
   input  logic [4:0]  priv_type,
   input  logic [3:0]  flags_in,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_rvalid,
   output logic        stall_out,
   output logic        rf_we_1,
   output logic [4:0]  rf_tgt_1,
   output logic [31:0] rf_data_1,
   output logic        rf_we_2,
   output logic [4:0]  rf_tgt_2,
   output logic [31:0] rf_data_2,
   output logic        cr_we,
   output logic [4:0]  cr_tgt,
   output logic [31:0] cr_data,
   output logic [3:0]  flags_out,
   output logic        exc_out_wb,
   output logic        rfe_out_wb,
   output logic [7:0]  exc_code_out,
   output logic [31:0] epc_out
`ifdef WB_RETIRE_COUNT_EN
   ,
   output logic [63:0] instret
`endif
);

   localparam logic [7:0] TimeoutC = 8'(LOAD_TIMEOUT);

   wb_state_e   r_state, w_state_nxt;
   logic [7:0]  r_count, w_count_nxt;
   logic        r_squash;
   logic [4:0]  r_tgt;
   logic [1:0]  r_addr_lo, r_size;
   logic [31:0] r_pc;

   logic        w_en, w_valid, w_capture, w_retire, w_exc, w_rfe, w_stall;
   logic        w_rf_we_1, w_rf_we_2, w_cr_we;
   logic [4:0]  w_rf_tgt_1, w_rf_tgt_2, w_cr_tgt;
   logic [31:0] w_rf_data_1, w_rf_data_2, w_cr_data, w_epc, w_load_data;
   logic [3:0]  w_flags;
   logic [7:0]  w_exc_code;
   logic [1:0]  w_la_addr, w_la_size;
   logic        w_unused_inputs;

   assign w_unused_inputs = ^{addr_in[31:2], opcode_in};

   assign w_en    = clk_en & ~halt;
   assign w_valid = ~bubble_in & ~r_squash;

   // While waiting, the captured slot fields drive the aligner.
   assign w_la_addr = (r_state == WAIT) ? r_addr_lo : addr_in[1:0];
   assign w_la_size = (r_state == WAIT) ? r_size : mem_size_in;

   load_align u_load_align (
      .i_rdata (dmem_rdata),
      .i_addr  (w_la_addr),
      .i_size  (w_la_size),
      .o_data  (w_load_data)
   );

   assign stall_out = w_stall;

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_capture   = 1'b0;
      w_stall     = 1'b0;
      w_rf_we_1   = 1'b0;
      w_rf_tgt_1  = rf_tgt_1;
      w_rf_data_1 = rf_data_1;
      w_rf_we_2   = 1'b0;
      w_rf_tgt_2  = rf_tgt_2;
      w_rf_data_2 = rf_data_2;
      w_cr_we     = 1'b0;
      w_cr_tgt    = cr_tgt;
      w_cr_data   = cr_data;
      w_flags     = flags_out;
      w_exc       = 1'b0;
      w_exc_code  = exc_code_out;
      w_epc       = epc_out;
      w_rfe       = 1'b0;
      w_retire    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_valid) begin
               if (exc_in != 8'h00) begin
                  w_exc      = 1'b1;
                  w_exc_code = exc_in;
                  w_epc      = mem_pc_in;
               end else if ((is_load | is_store) && is_misaligned) begin
                  w_exc      = 1'b1;
                  w_exc_code = EXC_MISALIGNED;
                  w_epc      = mem_pc_in;
               end else if (priv_type == PRIV_RFE) begin
                  w_rfe    = 1'b1;
                  w_retire = 1'b1;
               end else if (is_load) begin
                  if (dmem_rvalid) begin
                     w_rf_we_1   = (tgt_in_1 != 5'd0);
                     w_rf_tgt_1  = tgt_in_1;
                     w_rf_data_1 = w_load_data;
                     w_retire    = 1'b1;
                  end else begin
                     w_stall     = 1'b1;
                     w_state_nxt = WAIT;
                     w_count_nxt = 8'd1;
                     w_capture   = 1'b1;
                  end
               end else begin
                  if (tgts_cr) begin
                     w_cr_we   = 1'b1;
                     w_cr_tgt  = tgt_in_1;
                     w_cr_data = result_in_1;
                  end else begin
                     w_rf_we_1   = (tgt_in_1 != 5'd0);
                     w_rf_tgt_1  = tgt_in_1;
                     w_rf_data_1 = result_in_1;
                  end
                  w_rf_we_2   = (tgt_in_2 != 5'd0);
                  w_rf_tgt_2  = tgt_in_2;
                  w_rf_data_2 = result_in_2;
                  w_flags     = flags_in;
                  w_retire    = 1'b1;
               end
            end
         end
         WAIT: begin
            w_count_nxt = r_count + 8'd1;
            // Data arriving on the timeout cycle still wins over the bus error.
            if (dmem_rvalid) begin
               w_rf_we_1   = (r_tgt != 5'd0);
               w_rf_tgt_1  = r_tgt;
               w_rf_data_1 = w_load_data;
               w_retire    = 1'b1;
               w_state_nxt = IDLE;
               w_count_nxt = 8'd0;
            end else if (r_count >= TimeoutC) begin
               w_exc       = 1'b1;
               w_exc_code  = EXC_BUS;
               w_epc       = r_pc;
               w_state_nxt = IDLE;
               w_count_nxt = 8'd0;
            end else begin
               w_stall = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_count      <= 8'd0;
         r_squash     <= 1'b0;
         r_tgt        <= 5'd0;
         r_addr_lo    <= 2'b00;
         r_size       <= 2'b00;
         r_pc         <= 32'd0;
         rf_we_1      <= 1'b0;
         rf_tgt_1     <= 5'd0;
         rf_data_1    <= 32'd0;
         rf_we_2      <= 1'b0;
         rf_tgt_2     <= 5'd0;
         rf_data_2    <= 32'd0;
         cr_we        <= 1'b0;
         cr_tgt       <= 5'd0;
         cr_data      <= 32'd0;
         flags_out    <= 4'd0;
         exc_out_wb   <= 1'b0;
         rfe_out_wb   <= 1'b0;
         exc_code_out <= 8'd0;
         epc_out      <= 32'd0;
      end else if (!w_en) begin
         rf_we_1    <= 1'b0;
         rf_we_2    <= 1'b0;
         cr_we      <= 1'b0;
         exc_out_wb <= 1'b0;
         rfe_out_wb <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_count      <= w_count_nxt;
         r_squash     <= w_exc | w_rfe;
         if (w_capture) begin
            r_tgt     <= tgt_in_1;
            r_addr_lo <= addr_in[1:0];
            r_size    <= mem_size_in;
            r_pc      <= mem_pc_in;
         end
         rf_we_1      <= w_rf_we_1;
         rf_tgt_1     <= w_rf_tgt_1;
         rf_data_1    <= w_rf_data_1;
         rf_we_2      <= w_rf_we_2;
         rf_tgt_2     <= w_rf_tgt_2;
         rf_data_2    <= w_rf_data_2;
         cr_we        <= w_cr_we;
         cr_tgt       <= w_cr_tgt;
         cr_data      <= w_cr_data;
         flags_out    <= w_flags;
         exc_out_wb   <= w_exc;
         rfe_out_wb   <= w_rfe;
         exc_code_out <= w_exc_code;
         epc_out      <= w_epc;
      end
   end

`ifdef WB_RETIRE_COUNT_EN
   logic [63:0] r_instret;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_instret <= 64'd0;
      end else if (w_en && w_retire) begin
         r_instret <= r_instret + 64'd1;
      end
   end

   assign instret = r_instret;
`else
   logic w_unused_retire;
   assign w_unused_retire = w_retire;
`endif

endmodule

// File: tb/tb_writeback.sv
// Directed self-checking bench for writeback, built with LOAD_TIMEOUT = 4.
module tb_writeback;

   logic        clk = 1'b0;
   logic        rst, clk_en, halt, bubble_in;
   logic [4:0]  opcode_in, tgt_in_1, tgt_in_2, priv_type;
   logic [31:0] result_in_1, result_in_2, addr_in, mem_pc_in, dmem_rdata;
   logic        is_load, is_store, is_misaligned, tgts_cr, dmem_rvalid;
   logic [1:0]  mem_size_in;
   logic [7:0]  exc_in;
   logic [3:0]  flags_in;
   logic        stall_out, rf_we_1, rf_we_2, cr_we, exc_out_wb, rfe_out_wb;
   logic [4:0]  rf_tgt_1, rf_tgt_2, cr_tgt;
   logic [31:0] rf_data_1, rf_data_2, cr_data, epc_out;
   logic [3:0]  flags_out;
   logic [7:0]  exc_code_out;
`ifdef WB_RETIRE_COUNT_EN
   logic [63:0] instret;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   writeback #(.LOAD_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .halt(halt), .bubble_in(bubble_in),
      .opcode_in(opcode_in), .tgt_in_1(tgt_in_1), .tgt_in_2(tgt_in_2),
      .result_in_1(result_in_1), .result_in_2(result_in_2), .addr_in(addr_in),
      .is_load(is_load), .is_store(is_store), .is_misaligned(is_misaligned),
      .tgts_cr(tgts_cr), .mem_size_in(mem_size_in), .mem_pc_in(mem_pc_in),
      .exc_in(exc_in), .priv_type(priv_type), .flags_in(flags_in),
      .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid), .stall_out(stall_out),
      .rf_we_1(rf_we_1), .rf_tgt_1(rf_tgt_1), .rf_data_1(rf_data_1),
      .rf_we_2(rf_we_2), .rf_tgt_2(rf_tgt_2), .rf_data_2(rf_data_2),
      .cr_we(cr_we), .cr_tgt(cr_tgt), .cr_data(cr_data), .flags_out(flags_out),
      .exc_out_wb(exc_out_wb), .rfe_out_wb(rfe_out_wb),
      .exc_code_out(exc_code_out), .epc_out(epc_out)
`ifdef WB_RETIRE_COUNT_EN
      , .instret(instret)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs are then driven at +1 and sampled at +3.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic slot_clear();
      bubble_in = 1'b1; opcode_in = '0; tgt_in_1 = '0; tgt_in_2 = '0;
      result_in_1 = '0; result_in_2 = '0; addr_in = '0; is_load = 1'b0;
      is_store = 1'b0; is_misaligned = 1'b0; tgts_cr = 1'b0; mem_size_in = 2'b00;
      mem_pc_in = '0; exc_in = '0; priv_type = '0; flags_in = '0;
      dmem_rdata = '0; dmem_rvalid = 1'b0;
   endtask

   task automatic slot_alu(input logic [4:0] t1, input logic [31:0] r1, input logic [4:0] t2,
                           input logic [31:0] r2, input logic [31:0] pc);
      slot_clear();
      bubble_in = 1'b0; tgt_in_1 = t1; result_in_1 = r1; tgt_in_2 = t2;
      result_in_2 = r2; mem_pc_in = pc;
   endtask

   task automatic slot_load(input logic [4:0] t1, input logic [31:0] addr, input logic [1:0] sz,
                            input logic [31:0] pc);
      slot_clear();
      bubble_in = 1'b0; is_load = 1'b1; tgt_in_1 = t1; addr_in = addr;
      mem_size_in = sz; mem_pc_in = pc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; clk_en = 1'b1; halt = 1'b0;
      slot_clear();
      tick(); tick();
      rst = 1'b0;
      #2;
      check("reset rf_we_1", rf_we_1, 0);
      check("reset rf_data_1", rf_data_1, 0);
      check("reset exc_out_wb", exc_out_wb, 0);
      check("reset epc_out", epc_out, 0);
      check("reset flags_out", flags_out, 0);
      check("reset stall_out", stall_out, 0);

      // ALU commit, tgt 2 = 0 suppressed
      tick();
      slot_alu(5'd3, 32'h1234, 5'd0, 32'h55, 32'h100);
      flags_in = 4'hA;
      #2 check("alu stall", stall_out, 0);
      tick();
      slot_clear();
      check("alu rf_we_1", rf_we_1, 1);
      check("alu rf_tgt_1", rf_tgt_1, 3);
      check("alu rf_data_1", rf_data_1, 32'h1234);
      check("alu rf_we_2", rf_we_2, 0);
      check("alu cr_we", cr_we, 0);
      check("alu flags", flags_out, 4'hA);
      tick();
      check("alu we one cycle", rf_we_1, 0);

      // Control-register target plus second rf port
      slot_alu(5'd5, 32'hCAFE, 5'd7, 32'hBEEF, 32'h104);
      tgts_cr = 1'b1;
      tick();
      slot_clear();
      check("cr cr_we", cr_we, 1);
      check("cr cr_tgt", cr_tgt, 5);
      check("cr cr_data", cr_data, 32'hCAFE);
      check("cr rf_we_1", rf_we_1, 0);
      check("cr rf_we_2", rf_we_2, 1);
      check("cr rf_tgt_2", rf_tgt_2, 7);
      check("cr rf_data_2", rf_data_2, 32'hBEEF);

      // Byte load, response in the same cycle
      slot_load(5'd4, 32'h1002, 2'b00, 32'h108);
      dmem_rdata = 32'hAABBCCDD; dmem_rvalid = 1'b1;
      #2 check("ldb stall", stall_out, 0);
      tick();
      slot_clear();
      check("ldb rf_we_1", rf_we_1, 1);
      check("ldb rf_tgt_1", rf_tgt_1, 4);
      check("ldb rf_data_1", rf_data_1, 32'h000000BB);

      // Half load from upper half
      slot_load(5'd9, 32'h1002, 2'b01, 32'h10C);
      dmem_rdata = 32'hAABBCCDD; dmem_rvalid = 1'b1;
      tick();
      slot_clear();
      check("ldh rf_data_1", rf_data_1, 32'h0000AABB);

      // Load with response 3 cycles late
      slot_load(5'd10, 32'h2001, 2'b00, 32'h110);
      for (int i = 0; i < 3; i++) begin
         #2 check("dly stall", stall_out, 1);
         tick();
         check("dly no write", rf_we_1, 0);
      end
      dmem_rdata = 32'h11223344; dmem_rvalid = 1'b1;
      #2 check("dly stall drop", stall_out, 0);
      tick();
      slot_clear();
      check("dly rf_we_1", rf_we_1, 1);
      check("dly rf_tgt_1", rf_tgt_1, 10);
      check("dly rf_data_1", rf_data_1, 32'h00000033);
      tick();
      check("dly single write", rf_we_1, 0);

      // Timeout: 4 stall cycles then bus error
      slot_load(5'd11, 32'h3000, 2'b10, 32'h400);
      for (int i = 0; i < 4; i++) begin
         #2 check("tmo stall", stall_out, 1);
         tick();
      end
      #2 check("tmo stall drop", stall_out, 0);
      tick();
      slot_clear();
      check("tmo exc_out_wb", exc_out_wb, 1);
      check("tmo exc_code", exc_code_out, 8'h02);
      check("tmo epc", epc_out, 32'h400);
      check("tmo no write", rf_we_1, 0);
      tick();
      check("tmo pulse one cycle", exc_out_wb, 0);

      // Upstream exception, then the following slot is squashed
      slot_alu(5'd3, 32'h99, 5'd0, 32'h0, 32'h500);
      exc_in = 8'h05;
      tick();
      check("exc pulse", exc_out_wb, 1);
      check("exc code", exc_code_out, 8'h05);
      check("exc epc", epc_out, 32'h500);
      check("exc no write", rf_we_1, 0);
      slot_alu(5'd6, 32'h77, 5'd0, 32'h0, 32'h504);
      tick();
      check("squash no write", rf_we_1, 0);
      check("squash no exc", exc_out_wb, 0);
      tick();
      slot_clear();
      check("post squash write", rf_we_1, 1);
      check("post squash data", rf_data_1, 32'h77);

      // Misaligned load
      slot_load(5'd12, 32'h2001, 2'b10, 32'h600);
      is_misaligned = 1'b1;
      #2 check("mis stall", stall_out, 0);
      tick();
      slot_clear();
      check("mis exc", exc_out_wb, 1);
      check("mis code", exc_code_out, 8'h03);
      check("mis epc", epc_out, 32'h600);
      tick();

      // Return from exception
      slot_alu(5'd13, 32'h1, 5'd0, 32'h0, 32'h700);
      priv_type = 5'd2;
      tick();
      slot_clear();
      check("rfe pulse", rfe_out_wb, 1);
      check("rfe no write", rf_we_1, 0);
      check("rfe no exc", exc_out_wb, 0);
      tick();

      // Halt holds data and clears enables
      slot_alu(5'd8, 32'h99, 5'd0, 32'h0, 32'h800);
      halt = 1'b1;
      tick();
      check("halt no write", rf_we_1, 0);
      check("halt data hold", rf_data_1, 32'h77);
      halt = 1'b0;
      tick();
      slot_clear();
      check("unhalt write", rf_we_1, 1);
      check("unhalt data", rf_data_1, 32'h99);

      // Reset while waiting abandons the load
      slot_load(5'd14, 32'h0, 2'b10, 32'h900);
      tick();
      rst = 1'b1;
      slot_clear();
      tick();
      rst = 1'b0;
      dmem_rdata = 32'hDEADBEEF; dmem_rvalid = 1'b1;
      #2 check("rstw stall", stall_out, 0);
      tick();
      dmem_rvalid = 1'b0;
      check("rstw no write", rf_we_1, 0);
      check("rstw data zero", rf_data_1, 0);
      check("rstw no exc", exc_out_wb, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
